// File: rtl/pipe_pkg.sv
// pipe_pkg: shared write-back payload type and elastic-register state encoding.
package pipe_pkg;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_ADDR_WIDTH = 8;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic unsigned_load;
    logic [MAX_WIDTH-1:0] data;
    logic [MAX_WIDTH-1:0] ALUResult;
    logic [MAX_ADDR_WIDTH-1:0] Rd;
  } wb_payload_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + CNT_WIDTH'(1);
endmodule

// File: rtl/wb_skid_reg.sv
// wb_skid_reg: two-entry elastic write-back register (main + skid) with bubble counter.
module wb_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  RegWrite_in,
  input  logic                  MemtoReg_in,
  input  logic                  unsigned_load_in,
  input  logic [WIDTH-1:0]      data_in,
  input  logic [WIDTH-1:0]      ALUResult_in,
  input  logic [ADDR_WIDTH-1:0] Rd_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  RegWrite,
  output logic                  MemtoReg,
  output logic                  unsigned_load,
  output logic [WIDTH-1:0]      data,
  output logic [WIDTH-1:0]      ALUResult,
  output logic [ADDR_WIDTH-1:0] Rd,
  output logic [CNT_WIDTH-1:0]  bubble_count
);
  state_t state, state_nx;
  wb_payload_t main, skid, entry;
  logic acc, pop, load_main, load_skid, move, unused_bits;
  assign entry = {RegWrite_in, MemtoReg_in, unsigned_load_in, MAX_WIDTH'(data_in),
                  MAX_WIDTH'(ALUResult_in), MAX_ADDR_WIDTH'(Rd_in)};
  // ready decodes only the state register, so out_ready never reaches in_ready
  assign out_valid = state != EMPTY;
  assign in_ready = state != FULL;
  assign acc = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  always_comb begin
    state_nx = EMPTY;
    case (state)
      EMPTY:   state_nx = acc ? ONE : EMPTY;
      ONE:     state_nx = (acc && !pop) ? FULL : (pop && !acc) ? EMPTY : ONE;
      FULL:    state_nx = pop ? ONE : FULL;
      default: state_nx = EMPTY;
    endcase
    if (flush) state_nx = EMPTY;
    load_main = !flush && acc && (state == EMPTY || pop);
    load_skid = !flush && acc && !pop && state == ONE;
    move = !flush && pop && state == FULL;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      main <= '0;
      skid <= '0;
    end else begin
      state <= state_nx;
      if (load_main) main <= entry;
      else if (move) main <= skid;
      if (load_skid) skid <= entry;
    end
  assign RegWrite = main.RegWrite && out_valid && (main.Rd[ADDR_WIDTH-1:0] != '0);
  assign MemtoReg = main.MemtoReg;
  assign unsigned_load = main.unsigned_load;
  assign data = main.data[WIDTH-1:0];
  assign ALUResult = main.ALUResult[WIDTH-1:0];
  assign Rd = main.Rd[ADDR_WIDTH-1:0];
  assign unused_bits = ^main;
  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_bubble (
    .clk(clk),
    .rst(rst),
    .inc(!out_valid),
    .count(bubble_count)
  );
endmodule

// File: tb/tb_wb_skid_reg.sv
// tb_wb_skid_reg: queue-model scoreboard bench with directed and random traffic.
module tb_wb_skid_reg;
  localparam int W = 32, AW = 5, CW = 4;
  logic clk = 0, rst, flush, in_valid, in_ready, RegWrite_in, MemtoReg_in, unsigned_load_in;
  logic out_valid, out_ready, RegWrite, MemtoReg, unsigned_load;
  logic [W-1:0] data_in, ALUResult_in, data, ALUResult;
  logic [AW-1:0] Rd_in, Rd;
  logic [CW-1:0] bubble_count;
  typedef struct packed {
    logic rw; logic m2r; logic ul; logic [W-1:0] d; logic [W-1:0] alu; logic [AW-1:0] rd;
  } ent_t;
  ent_t q[$];
  int bub, sz;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  wb_skid_reg #(.WIDTH(W), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .unsigned_load_in(unsigned_load_in),
    .data_in(data_in), .ALUResult_in(ALUResult_in), .Rd_in(Rd_in),
    .out_valid(out_valid), .out_ready(out_ready), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .unsigned_load(unsigned_load), .data(data), .ALUResult(ALUResult), .Rd(Rd),
    .bubble_count(bubble_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // reference: a FIFO of at most two accepted entries, bubbles counted while it is empty
  always @(posedge clk or posedge rst)
    if (rst) begin
      q.delete();
      bub <= 0;
    end else begin
      sz = q.size();
      if (sz == 0 && bub < 15) bub <= bub + 1;
      if (flush) q.delete();
      else begin
        if (sz > 0 && out_ready) void'(q.pop_front());
        if (in_valid && sz < 2)
          q.push_back({RegWrite_in, MemtoReg_in, unsigned_load_in, data_in, ALUResult_in, Rd_in});
      end
    end
  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("bubble_count", 32'(bubble_count), bub);
    if (q.size() > 0 && out_valid) begin
      chk("head_ALUResult", ALUResult, q[0].alu);
      chk("head_data", data, q[0].d);
      chk("head_Rd", 32'(Rd), 32'(q[0].rd));
      chk("head_MemtoReg", 32'(MemtoReg), 32'(q[0].m2r));
      chk("head_unsigned_load", 32'(unsigned_load), 32'(q[0].ul));
      chk("head_RegWrite", 32'(RegWrite), 32'(q[0].rw && q[0].rd != 0));
    end
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic put(input logic [31:0] alu, input logic [4:0] rd, input logic rw);
    in_valid = 1;
    ALUResult_in = alu;
    Rd_in = rd;
    RegWrite_in = rw;
    MemtoReg_in = 1'($urandom);
    unsigned_load_in = 1'($urandom);
    data_in = $urandom;
  endtask
  initial begin
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; RegWrite_in = 0; MemtoReg_in = 0;
    unsigned_load_in = 0; data_in = 0; ALUResult_in = 0; Rd_in = 0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    cyc(2);
    rst = 0;
    out_ready = 1;
    put(32'hAA, 5, 1);
    cyc(1);
    in_valid = 0;
    chk("first_valid", 32'(out_valid), 1);
    chk("first_alu", ALUResult, 32'hAA);
    chk("first_rd", 32'(Rd), 5);
    chk("first_regwrite", 32'(RegWrite), 1);
    cyc(1);
    chk("first_popped", 32'(out_valid), 0);
    out_ready = 0;
    put(1, 1, 1);
    cyc(1);
    put(2, 2, 1);
    cyc(1);
    in_valid = 0;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_head_a", ALUResult, 1);
    cyc(1);
    chk("stall_head_a", ALUResult, 1);
    out_ready = 1;
    cyc(1);
    chk("drain_head_b", ALUResult, 2);
    chk("drain_in_ready", 32'(in_ready), 1);
    cyc(1);
    chk("drain_empty", 32'(out_valid), 0);
    out_ready = 0;
    put(4, 4, 1);
    cyc(1);
    put(5, 5, 1);
    cyc(1);
    put(3, 3, 1);
    flush = 1;
    cyc(1);
    flush = 0;
    in_valid = 0;
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    out_ready = 1;
    cyc(3);
    chk("flush_no_c", 32'(out_valid), 0);
    out_ready = 0;
    put(7, 0, 1);
    cyc(1);
    in_valid = 0;
    chk("x0_valid", 32'(out_valid), 1);
    chk("x0_regwrite", 32'(RegWrite), 0);
    out_ready = 1;
    cyc(1);
    rst = 1;
    cyc(1);
    rst = 0;
    cyc(10);
    chk("bubble_10", 32'(bubble_count), 10);
    cyc(10);
    chk("bubble_sat", 32'(bubble_count), 15);
    out_ready = 0;
    put(9, 9, 1);
    MemtoReg_in = 1;
    unsigned_load_in = 1;
    cyc(1);
    put(10, 10, 1);
    cyc(1);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_regwrite", 32'(RegWrite), 0);
    chk("arst_memtoreg", 32'(MemtoReg), 0);
    chk("arst_unsigned", 32'(unsigned_load), 0);
    chk("arst_data", data, 0);
    chk("arst_alu", ALUResult, 0);
    chk("arst_rd", 32'(Rd), 0);
    chk("arst_bubble", 32'(bubble_count), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    cyc(1);
    rst = 0;
    repeat (600) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush = ($urandom % 16) == 0;
      RegWrite_in = 1'($urandom);
      MemtoReg_in = 1'($urandom);
      unsigned_load_in = 1'($urandom);
      data_in = $urandom;
      ALUResult_in = $urandom;
      Rd_in = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      cyc(1);
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    cyc(4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
